div_controller: RTL

Sequencing controller for the iterative unsigned 32-bit divider core in the RV32M execute stage. It accepts DIV/DIVU/REM/REMU requests from the pipeline and converts signed operands to magnitudes. It resolves special cases without starting the core, drives the core's start/done handshake, and restores signs on the result. It also keeps a one-entry result cache so a DIV/REM pair on the same operands costs one core run.

---
 rtl/div_controller.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/div_controller.sv
// Sequencing controller for the iterative unsigned divider core: operand sign handling,
// special-case bypass, core start/done handshake, flush draining and a one-entry result cache.
module div_controller #(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_done
);

  typedef enum logic [2:0] {IDLE, START, WAIT, DONE, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [31:0] raw_a_q, raw_a_d, raw_b_q, raw_b_d;
  logic [31:0] div_a_q, div_a_d, div_b_q, div_b_d;
  logic [31:0] res_q, res_d;
  logic        cache_vld_q, cache_vld_d, cache_uns_q, cache_uns_d;
  logic [31:0] cache_a_q, cache_a_d, cache_b_q, cache_b_d;
  logic [31:0] cache_quo_q, cache_quo_d, cache_rem_q, cache_rem_d;

  logic        accept, req_signed, in_sign_a, in_sign_b, cache_hit, big_uq;
  logic [31:0] mag_a, mag_b, big_ur, big_q, big_r, core_q, core_r;

  assign accept     = (state_q == IDLE) && req_valid && !flush;
  assign req_signed = !req_op[0];
  assign in_sign_a  = req_signed && req_a[31];
  assign in_sign_b  = req_signed && req_b[31];
  assign mag_a      = in_sign_a ? -req_a : req_a;
  assign mag_b      = in_sign_b ? -req_b : req_b;

  // Divisor magnitude with bit 31 set is beyond the core, so the quotient can only be 0 or 1.
  assign big_uq = (mag_a >= mag_b);
  assign big_ur = mag_a - (big_uq ? mag_b : 32'd0);
  assign big_q  = (in_sign_a ^ in_sign_b) ? -{31'd0, big_uq} : {31'd0, big_uq};
  assign big_r  = in_sign_a ? -big_ur : big_ur;

  assign cache_hit = CACHE_EN && cache_vld_q && (cache_a_q == req_a) &&
                     (cache_b_q == req_b) && (cache_uns_q == req_op[0]);

  assign core_q = (sign_a_q ^ sign_b_q) ? -div_q : div_q;
  assign core_r = sign_a_q ? -div_r : div_r;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    raw_a_d     = raw_a_q;
    raw_b_d     = raw_b_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    res_d       = res_q;
    cache_vld_d = cache_vld_q;
    cache_uns_d = cache_uns_q;
    cache_a_d   = cache_a_q;
    cache_b_d   = cache_b_q;
    cache_quo_d = cache_quo_q;
    cache_rem_d = cache_rem_q;
    div_start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d     = req_op;
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          raw_a_d  = req_a;
          raw_b_d  = req_b;
          state_d  = DONE;
          if (req_b == 32'd0) begin
            res_d = req_op[1] ? req_a : 32'hFFFF_FFFF;
          end else if (req_signed && req_a == 32'h8000_0000 && req_b == 32'hFFFF_FFFF) begin
            res_d = req_op[1] ? 32'd0 : 32'h8000_0000;
          end else if (mag_b[31]) begin
            res_d = req_op[1] ? big_r : big_q;
          end else if (cache_hit) begin
            res_d = req_op[1] ? cache_rem_q : cache_quo_q;
          end else begin
            div_a_d = mag_a;
            div_b_d = mag_b;
            state_d = START;
          end
        end
      end
      START: begin
        div_start = 1'b1;
        state_d   = flush ? DRAIN : WAIT;
      end
      WAIT: begin
        if (div_done) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            res_d       = op_q[1] ? core_r : core_q;
            cache_vld_d = 1'b1;
            cache_uns_d = op_q[0];
            cache_a_d   = raw_a_q;
            cache_b_d   = raw_b_q;
            cache_quo_d = core_q;
            cache_rem_d = core_r;
            state_d     = DONE;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      DRAIN:   if (div_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= 2'd0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      raw_a_q     <= 32'd0;
      raw_b_q     <= 32'd0;
      div_a_q     <= 32'd0;
      div_b_q     <= 32'd0;
      res_q       <= 32'd0;
      cache_vld_q <= 1'b0;
      cache_uns_q <= 1'b0;
      cache_a_q   <= 32'd0;
      cache_b_q   <= 32'd0;
      cache_quo_q <= 32'd0;
      cache_rem_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      raw_a_q     <= raw_a_d;
      raw_b_q     <= raw_b_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      res_q       <= res_d;
      cache_vld_q <= cache_vld_d;
      cache_uns_q <= cache_uns_d;
      cache_a_q   <= cache_a_d;
      cache_b_q   <= cache_b_d;
      cache_quo_q <= cache_quo_d;
      cache_rem_q <= cache_rem_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE) && !flush;
  assign resp_data  = (state_q == DONE) ? res_q : 32'd0;
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;

endmodule
